// File: rtl/simd_wb_buffer_pkg.sv
// Shared types and widths for the SIMD writeback buffer.
// Entries carry one result vector plus its regfile destination.
package simd_wb_buffer_pkg;
    localparam int VREG_W   = 256;
    localparam int RF_IDX_W = 5;
    localparam int RF_MUX_W = 2;

    typedef struct packed {
        logic [VREG_W-1:0]   data;
        logic [RF_IDX_W-1:0] idx;
        logic [RF_MUX_W-1:0] mux;
    } wb_entry_t;
endpackage

// File: rtl/simd_wb_buffer_if.sv
// Vector regfile write port: the buffer is master,
// the regfile grants with wr_rdy.
interface simd_wb_buffer_if;
    import simd_wb_buffer_pkg::*;

    logic [VREG_W-1:0]   wr_data;
    logic                wr_v;
    logic [RF_IDX_W-1:0] wr_idx;
    logic [RF_MUX_W-1:0] wr_mux;
    logic                wr_rdy;

    modport master (
        output wr_data, wr_v, wr_idx, wr_mux,
        input  wr_rdy
    );

    modport slave (
        input  wr_data, wr_v, wr_idx, wr_mux,
        output wr_rdy
    );
endinterface

// File: rtl/simd_wb_buffer_fifo.sv
// Synchronous FIFO of wb_entry_t with per-entry valid bits
// exposed so the owner can search pending destinations.
module simd_wb_fifo
    import simd_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  wb_entry_t             i_wdata,
    output wb_entry_t             o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output wb_entry_t [DEPTH-1:0] o_mem,
    output logic      [DEPTH-1:0] o_vld
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [DEPTH-1:0]      vld_q, vld_d;
    wb_entry_t [DEPTH-1:0] mem_q;
    logic                  do_push, do_pop;

    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        if (do_push) begin
            wr_ptr_d        = wr_ptr_q + 1'b1;
            vld_d[wr_ptr_q] = 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d        = rd_ptr_q + 1'b1;
            vld_d[rd_ptr_q] = 1'b0;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Payload is left unreset; the valid gate below hides stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_wdata;
    end

    assign o_rdata = vld_q[rd_ptr_q] ? mem_q[rd_ptr_q] : '0;
    assign o_mem   = mem_q;
    assign o_vld   = vld_q;
endmodule

// File: rtl/simd_wb_buffer.sv
// Queues SIMD results for the vector regfile write port and
// answers RAW-hazard lookups against pending destinations.
module simd_wb_buffer
    import simd_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VREG_W-1:0]     i_data,
    input  logic                  i_data_v,
    input  logic [RF_IDX_W-1:0]   i_rf_idx,
    input  logic [RF_MUX_W-1:0]   i_rf_mux,
    output logic                  o_full,
    output logic                  o_ovf,
    simd_wb_buffer_if.master      wr,
    input  logic [RF_IDX_W-1:0]   i_chk_idx,
    input  logic [RF_MUX_W-1:0]   i_chk_mux,
    output logic                  o_chk_hit
);
    wb_entry_t             in_ent, head;
    wb_entry_t [DEPTH-1:0] mem;
    logic      [DEPTH-1:0] vld;
    logic                  empty, pop;
    logic                  ovf_q, ovf_d;

    assign in_ent = '{data: i_data, idx: i_rf_idx, mux: i_rf_mux};
    assign pop    = !empty && wr.wr_rdy;

    simd_wb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (i_data_v),
        .i_pop   (pop),
        .i_wdata (in_ent),
        .o_rdata (head),
        .o_full  (o_full),
        .o_empty (empty),
        .o_mem   (mem),
        .o_vld   (vld)
    );

    assign wr.wr_v    = !empty;
    assign wr.wr_data = head.data;
    assign wr.wr_idx  = head.idx;
    assign wr.wr_mux  = head.mux;

    always_comb begin
        ovf_d = ovf_q | (i_data_v & o_full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign o_ovf = ovf_q;

    // A popping head is still pending until the edge, so it still hits.
    always_comb begin
        o_chk_hit = i_data_v && !o_full &&
                    (i_rf_idx == i_chk_idx) &&
                    (i_rf_mux == i_chk_mux);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && mem[i].idx == i_chk_idx &&
                mem[i].mux == i_chk_mux)
                o_chk_hit = 1'b1;
        end
    end
endmodule

// File: tb/tb_simd_wb_buffer.sv
// Randomized and directed bench for simd_wb_buffer against
// a queue-based model of the writeback FIFO.
module tb_simd_wb_buffer;
    import simd_wb_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [VREG_W-1:0]   i_data;
    logic                i_data_v;
    logic [RF_IDX_W-1:0] i_rf_idx;
    logic [RF_MUX_W-1:0] i_rf_mux;
    logic                o_full, o_ovf, o_chk_hit;
    logic [RF_IDX_W-1:0] i_chk_idx;
    logic [RF_MUX_W-1:0] i_chk_mux;

    simd_wb_buffer_if wr_if();

    simd_wb_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_data    (i_data),
        .i_data_v  (i_data_v),
        .i_rf_idx  (i_rf_idx),
        .i_rf_mux  (i_rf_mux),
        .o_full    (o_full),
        .o_ovf     (o_ovf),
        .wr        (wr_if),
        .i_chk_idx (i_chk_idx),
        .i_chk_mux (i_chk_mux),
        .o_chk_hit (o_chk_hit)
    );

    always #5 clk = ~clk;

    wb_entry_t mq[$];
    bit        m_ovf;
    int        checks = 0;
    int        errors = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input bit dv, input logic [255:0] d,
                         input logic [4:0] idx, input logic [1:0] mux,
                         input bit rdy,
                         input logic [4:0] qi, input logic [1:0] qm);
        wb_entry_t e, h;
        bit efull, ev, ehit;
        e.data = d; e.idx = idx; e.mux = mux;
        i_data = d; i_data_v = dv; i_rf_idx = idx; i_rf_mux = mux;
        wr_if.wr_rdy = rdy; i_chk_idx = qi; i_chk_mux = qm;
        @(negedge clk);
        efull = (mq.size() == DEPTH);
        ev    = (mq.size() != 0);
        h     = ev ? mq[0] : '0;
        ehit  = dv && !efull && idx == qi && mux == qm;
        foreach (mq[k])
            if (mq[k].idx == qi && mq[k].mux == qm) ehit = 1;
        chk("wr_v", 256'(wr_if.wr_v), 256'(ev));
        chk("full", 256'(o_full), 256'(efull));
        chk("ovf", 256'(o_ovf), 256'(m_ovf));
        chk("chk_hit", 256'(o_chk_hit), 256'(ehit));
        chk("wr_idx", 256'(wr_if.wr_idx), 256'(h.idx));
        chk("wr_mux", 256'(wr_if.wr_mux), 256'(h.mux));
        chk("wr_data", wr_if.wr_data, h.data);
        @(posedge clk);
        if (dv && efull) m_ovf = 1;
        if (ev && rdy) void'(mq.pop_front());
        if (dv && !efull) mq.push_back(e);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cycle(0, '0, '0, '0, rdy, 5'd31, 2'd3);
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && mq.size() != 0; k++) idle(1);
        chk("drained", 256'(mq.size()), 256'(0));
    endtask

    initial begin
        logic [255:0] a5;
        int n;
        a5 = {32{8'hA5}};
        rst_n = 0; i_data = '0; i_data_v = 0; i_rf_idx = '0;
        i_rf_mux = '0; wr_if.wr_rdy = 0; i_chk_idx = '0; i_chk_mux = '0;
        m_ovf = 0;
        #12;
        chk("rst_wr_v", 256'(wr_if.wr_v), 256'(0));
        chk("rst_full", 256'(o_full), 256'(0));
        chk("rst_ovf", 256'(o_ovf), 256'(0));
        chk("rst_wr_data", wr_if.wr_data, 256'(0));
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // single push, immediate grant
        cycle(1, a5, 5'd3, 2'd1, 1, 5'd0, 2'd0);
        idle(1);
        idle(1);

        // fill, drop a fifth, drain in order
        for (int k = 1; k <= 4; k++)
            cycle(1, rnd256(), 5'(k), 2'd0, 0, 5'd0, 2'd0);
        cycle(1, rnd256(), 5'd5, 2'd0, 0, 5'd5, 2'd0);
        chk("ovf_set", 256'(o_ovf), 256'(1));
        drain();

        // full with push and pop together
        for (int k = 0; k < 4; k++)
            cycle(1, rnd256(), 5'(10 + k), 2'd2, 0, 5'd0, 2'd0);
        cycle(1, rnd256(), 5'd20, 2'd2, 1, 5'd20, 2'd2);
        chk("full_after_pp", 256'(o_full), 256'(0));
        drain();

        // stream of 10 with alternating grant
        n = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            bit dv;
            dv = (mq.size() < DEPTH);
            cycle(dv, rnd256(), 5'(n), 2'd1, (c % 2) == 0, 5'd0, 2'd0);
            if (dv) n++;
        end
        chk("stream_count", 256'(n), 256'(10));
        drain();

        // hazard lookups
        cycle(1, rnd256(), 5'd7, 2'd2, 0, 5'd7, 2'd2);
        idle(0);
        cycle(0, '0, '0, '0, 0, 5'd7, 2'd2);
        cycle(0, '0, '0, '0, 0, 5'd7, 2'd1);
        cycle(1, rnd256(), 5'd9, 2'd0, 0, 5'd9, 2'd0);
        cycle(0, '0, '0, '0, 1, 5'd7, 2'd2);
        cycle(0, '0, '0, '0, 0, 5'd7, 2'd2);
        drain();

        // random traffic
        for (int c = 0; c < 400; c++)
            cycle($urandom_range(0, 9) < 6, rnd256(),
                  5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));

        // async reset with entries queued
        drain();
        for (int k = 0; k < 3; k++)
            cycle(1, rnd256(), 5'(k + 1), 2'd3, 0, 5'd0, 2'd0);
        i_data_v = 0; i_chk_idx = 5'd1; i_chk_mux = 2'd3;
        #2; rst_n = 0; #1;
        chk("ar_wr_v", 256'(wr_if.wr_v), 256'(0));
        chk("ar_full", 256'(o_full), 256'(0));
        chk("ar_ovf", 256'(o_ovf), 256'(0));
        chk("ar_hit", 256'(o_chk_hit), 256'(0));
        mq.delete(); m_ovf = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        cycle(1, a5, 5'd30, 2'd1, 0, 5'd30, 2'd1);
        cycle(1, rnd256(), 5'd31, 2'd0, 1, 5'd30, 2'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/simd_wb_buffer.md
Name: simd_wb_buffer

Overview:
Writeback-side companion of the SIMD input pre-register. It accepts 256-bit SIMD results with their vector-regfile destination tags and queues them in a small FIFO. It then drives the vector regfile write port under a valid/ready handshake. It also gives the issue side a full flag, a sticky overflow flag and a combinational RAW-hazard lookup on pending destinations.

Parameters:
DEPTH, 4, number of queued result entries; power of two, minimum 2
PTR_W, 2, pointer width, equal to log2(DEPTH)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
i_data  input  256  SIMD result vector
i_data_v  input  1  result valid; one push per cycle
i_rf_idx  input  5  destination vector register index
i_rf_mux  input  2  destination regfile bank select
o_full  output  1  FIFO full; upstream must hold results
o_ovf  output  1  sticky overflow; set when a push is dropped
o_wr_data  output  256  regfile write data (head entry)
o_wr_v  output  1  regfile write valid
o_wr_idx  output  5  regfile write index
o_wr_mux  output  2  regfile write bank select
i_wr_rdy  input  1  regfile write port granted this cycle
i_chk_idx  input  5  hazard query index (from the read side)
i_chk_mux  input  2  hazard query bank
o_chk_hit  output  1  a pending or incoming write matches the query

Behaviour:
- Reset, asynchronous on rst_n low:
  - count = 0; wr_ptr = 0; rd_ptr = 0.
  - All entry valid bits = 0.
  - o_ovf = 0.
  - Derived outputs: o_wr_v = 0, o_full = 0, o_chk_hit = 0 unless i_data_v matches.
  - Payload storage is not reset. o_wr_data, o_wr_idx and o_wr_mux read 0 after reset because the storage read is gated by the valid bit.
- Reset may assert mid-transfer. All queued entries are discarded and no partial write is held.
- push = i_data_v && !o_full. The entry {data, idx, mux} is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- pop = o_wr_v && i_wr_rdy. rd_ptr advances modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on push and pop together.
- o_wr_v = (count != 0). o_wr_data, o_wr_idx and o_wr_mux present the entry at rd_ptr, read directly from registered storage.
- Latency: a result pushed in cycle N appears on o_wr_* in cycle N+1 if the FIFO was empty; otherwise it appears after all older entries have popped.
- The head entry stays stable while o_wr_v && !i_wr_rdy. The order of o_wr_* across pops is strict FIFO.
- o_full = (count == DEPTH), combinational from count.
  - A push while full is refused even if a pop happens in the same cycle.
  - The refused result is dropped and o_ovf is set to 1 in the next cycle. o_ovf stays at 1 until reset.
  - Upstream must stall on o_full; o_ovf is a debug error flag.
- Pointer wrap: wr_ptr and rd_ptr wrap from DEPTH-1 to 0. Full and empty are distinguished by count, never by pointer equality.
- o_chk_hit is combinational and asserts if either of these holds:
  - any valid stored entry has idx == i_chk_idx and mux == i_chk_mux;
  - i_data_v && !o_full && i_rf_idx == i_chk_idx && i_rf_mux == i_chk_mux.
- An entry that pops in the current cycle still counts as a hit in that cycle.
- Duplicate destinations may be queued. They are written in order, so the last write wins in the regfile.

Decomposition:
- Shared package holds:
  - constants VREG_W = 256, RF_IDX_W = 5, RF_MUX_W = 2;
  - typedef wb_entry_t = {data, idx, mux}.
- One natural sub-module: simd_wb_fifo, a generic synchronous FIFO with count, full and empty, holding wb_entry_t plus per-entry valid bits exposed for the hazard compare.
- The hazard compare logic stays in the top module.

Test Plan:
- Reset then a single push {data = 256'hA5..A5, idx = 3, mux = 1} with i_wr_rdy = 1: o_wr_v = 1 in cycle N+1 with idx 3 and mux 1; o_wr_v = 0 in N+2; count returns to 0.
- Four pushes (idx 1,2,3,4) with i_wr_rdy = 0: o_full = 1 after the 4th push. A 5th push (idx 5) is dropped and o_ovf = 1 the next cycle. Then hold i_wr_rdy = 1: writes appear in order 1,2,3,4 and idx 5 never appears.
- Full FIFO with push and pop in the same cycle: the push is refused, count becomes 3 and o_ovf = 1.
- Steady stream of 10 pushes with i_wr_rdy toggling 1,0: no drops, strict order, the head is stable during rdy = 0 cycles, and the pointers wrap twice cleanly.
- Hazard: queue idx 7 / mux 2, query idx 7 / mux 2 gives hit = 1; query idx 7 / mux 1 gives 0. An incoming i_data_v with idx 9 and query 9 gives a hit in the same cycle. After the idx 7 pop completes, hit = 0.
- Assert rst_n low with 3 entries queued and o_wr_v = 1: o_wr_v, o_full, o_ovf and o_chk_hit drop to 0 immediately (asynchronously). After release the first new push appears as the first write.
